// File: rtl/cu_pkg.sv
// Shared codes for the nibble-ISA computational unit:
// bus source selects, ALU functions, write-enable bits, timer states.
package cu_pkg;

  localparam logic [3:0] SRC_X0  = 4'd0;
  localparam logic [3:0] SRC_X1  = 4'd1;
  localparam logic [3:0] SRC_Y0  = 4'd2;
  localparam logic [3:0] SRC_Y1  = 4'd3;
  localparam logic [3:0] SRC_R   = 4'd4;
  localparam logic [3:0] SRC_M   = 4'd5;
  localparam logic [3:0] SRC_I   = 4'd6;
  localparam logic [3:0] SRC_DM  = 4'd7;
  localparam logic [3:0] SRC_IMM = 4'd8;
  localparam logic [3:0] SRC_PIN = 4'd9;
  localparam logic [3:0] SRC_TMR = 4'd10;

  localparam logic [2:0] ALU_NEG  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_MULH = 3'd3;
  localparam logic [2:0] ALU_MULL = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;
  localparam logic [2:0] ALU_AND  = 3'd6;
  localparam logic [2:0] ALU_NOT  = 3'd7;

  localparam int REN_X0  = 0;
  localparam int REN_X1  = 1;
  localparam int REN_Y0  = 2;
  localparam int REN_Y1  = 3;
  localparam int REN_R   = 4;
  localparam int REN_M   = 5;
  localparam int REN_I   = 6;
  localparam int REN_NC  = 7;
  localparam int REN_O   = 8;
  localparam int REN_PER = 9;

  typedef enum logic [1:0] {
    TMR_IDLE,
    TMR_RUN,
    TMR_DONE
  } tmr_state_t;

endpackage

// File: rtl/cu_alu.sv
// Combinational ALU: result, carry/borrow and zero detect.
// fn[3] turns functions 000 and 111 into a pass-through of r.
module cu_alu
  import cu_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic [3:0]    fn,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  input  logic [DW-1:0] r,
  output logic [DW-1:0] res,
  output logic          c_upd,
  output logic          c_val,
  output logic          zero
);

  logic [2*DW-1:0] prod;
  logic [DW:0]     sum;
  logic [DW:0]     diff;

  always_comb begin
    prod  = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
    sum   = {1'b0, x} + {1'b0, y};
    diff  = {1'b0, x} - {1'b0, y};
    res   = '0;
    c_upd = 1'b0;
    c_val = 1'b0;
    unique case (fn[2:0])
      ALU_NEG:  res = fn[3] ? r : -x;
      ALU_SUB: begin
        res   = diff[DW-1:0];
        c_upd = 1'b1;
        c_val = diff[DW];
      end
      ALU_ADD: begin
        res   = sum[DW-1:0];
        c_upd = 1'b1;
        c_val = sum[DW];
      end
      ALU_MULH: res = prod[2*DW-1:DW];
      ALU_MULL: res = prod[DW-1:0];
      ALU_XOR:  res = x ^ y;
      ALU_AND:  res = x & y;
      ALU_NOT:  res = fn[3] ? r : ~x;
      default:  res = '0;
    endcase
  end

  assign zero = (res == '0);

endmodule

// File: rtl/computational_unit_gen.sv
// DW-bit computational unit with carry flag and an interval
// timer raising a latched, acknowledged interrupt request.
module computational_unit_gen
  import cu_pkg::*;
#(
  parameter int DW       = 4,
  parameter int TW       = 8,
  parameter int TMR_AUTO = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    ir_nibble,
  input  logic [3:0]    source_sel,
  input  logic [9:0]    reg_en,
  input  logic          i_sel,
  input  logic          x_sel,
  input  logic          y_sel,
  input  logic [DW-1:0] dm,
  input  logic [DW-1:0] i_pins,
  input  logic          isr,
  output logic [DW-1:0] data_bus,
  output logic [DW-1:0] x0,
  output logic [DW-1:0] x1,
  output logic [DW-1:0] y0,
  output logic [DW-1:0] y1,
  output logic [DW-1:0] r,
  output logic [DW-1:0] m,
  output logic [DW-1:0] i,
  output logic [DW-1:0] o_reg,
  output logic          r_eq_0,
  output logic          r_carry,
  output logic          interrupt,
  output logic [TW-1:0] timer
);

  logic [DW-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [DW-1:0] r_q, r_d, m_q, m_d, i_q, i_d, o_q, o_d;
  logic          eq_q, eq_d, c_q, c_d;
  logic [TW-1:0] timer_q, timer_d, period_q, period_d;
  logic          pend_q, pend_d, isr_d_q, isr_d_d;
  tmr_state_t    st_q, st_d;
  logic          term;

  logic [DW-1:0] alu_x, alu_y, alu_res;
  logic          c_upd, c_val, alu_zero;
  logic          unused_nc;

  assign unused_nc = reg_en[REN_NC];
  assign alu_x     = x_sel ? x1_q : x0_q;
  assign alu_y     = y_sel ? y1_q : y0_q;

  cu_alu #(.DW(DW)) u_alu (
    .fn    (ir_nibble),
    .x     (alu_x),
    .y     (alu_y),
    .r     (r_q),
    .res   (alu_res),
    .c_upd (c_upd),
    .c_val (c_val),
    .zero  (alu_zero)
  );

  always_comb begin
    case (source_sel)
      SRC_X0:  data_bus = x0_q;
      SRC_X1:  data_bus = x1_q;
      SRC_Y0:  data_bus = y0_q;
      SRC_Y1:  data_bus = y1_q;
      SRC_R:   data_bus = r_q;
      SRC_M:   data_bus = m_q;
      SRC_I:   data_bus = i_q;
      SRC_DM:  data_bus = dm;
      SRC_IMM: data_bus = DW'(ir_nibble);
      SRC_PIN: data_bus = i_pins;
      SRC_TMR: data_bus = timer_q[DW-1:0];
      default: data_bus = '0;
    endcase
  end

  always_comb begin
    x0_d = reg_en[REN_X0] ? data_bus : x0_q;
    x1_d = reg_en[REN_X1] ? data_bus : x1_q;
    y0_d = reg_en[REN_Y0] ? data_bus : y0_q;
    y1_d = reg_en[REN_Y1] ? data_bus : y1_q;
    m_d  = reg_en[REN_M]  ? data_bus : m_q;
    o_d  = reg_en[REN_O]  ? data_bus : o_q;
    r_d  = reg_en[REN_R]  ? alu_res  : r_q;
    eq_d = reg_en[REN_R]  ? alu_zero : eq_q;
    c_d  = (reg_en[REN_R] && c_upd) ? c_val : c_q;
    i_d  = i_q;
    if (reg_en[REN_I])
      i_d = i_sel ? i_q + m_q : data_bus;
  end

  // A period write overrides whatever the counter would do this edge.
  always_comb begin
    st_d     = st_q;
    timer_d  = timer_q;
    period_d = period_q;
    term     = 1'b0;
    if (reg_en[REN_PER]) begin
      period_d = TW'(data_bus);
      timer_d  = TW'(data_bus);
      st_d     = (period_d == '0) ? TMR_IDLE : TMR_RUN;
    end else begin
      unique case (st_q)
        TMR_RUN: begin
          if (timer_q == '0) begin
            timer_d = period_q;
          end else if (timer_q == TW'(1)) begin
            term    = 1'b1;
            timer_d = '0;
            if (TMR_AUTO == 0) st_d = TMR_DONE;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        default: timer_d = '0;
      endcase
    end
    isr_d_d = isr;
    pend_d  = term | (pend_q & ~(isr & ~isr_d_q));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      r_q      <= '0;
      m_q      <= '0;
      i_q      <= '0;
      o_q      <= '0;
      eq_q     <= 1'b1;
      c_q      <= 1'b0;
      timer_q  <= '0;
      period_q <= '0;
      pend_q   <= 1'b0;
      isr_d_q  <= 1'b0;
      st_q     <= TMR_IDLE;
    end else begin
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      r_q      <= r_d;
      m_q      <= m_d;
      i_q      <= i_d;
      o_q      <= o_d;
      eq_q     <= eq_d;
      c_q      <= c_d;
      timer_q  <= timer_d;
      period_q <= period_d;
      pend_q   <= pend_d;
      isr_d_q  <= isr_d_d;
      st_q     <= st_d;
    end
  end

  assign x0        = x0_q;
  assign x1        = x1_q;
  assign y0        = y0_q;
  assign y1        = y1_q;
  assign r         = r_q;
  assign m         = m_q;
  assign i         = i_q;
  assign o_reg     = o_q;
  assign r_eq_0    = eq_q;
  assign r_carry   = c_q;
  assign interrupt = pend_q & ~isr;
  assign timer     = timer_q;

endmodule

// File: tb/tb_computational_unit_gen.sv
// Directed bench: three instances (DW=4 auto, DW=8 auto,
// DW=4 one-shot) sharing control inputs.
module tb_computational_unit_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ir_nibble, source_sel;
  logic [9:0] reg_en;
  logic       i_sel, x_sel, y_sel, isr;
  logic [3:0] dm4, pins4;
  logic [7:0] dm8, pins8;

  logic [3:0] a_bus, a_x0, a_x1, a_y0, a_y1, a_r, a_m, a_i, a_o;
  logic       a_eq, a_c, a_int;
  logic [7:0] a_tmr;
  logic [7:0] b_bus, b_x0, b_x1, b_y0, b_y1, b_r, b_m, b_i, b_o;
  logic       b_eq, b_c, b_int;
  logic [7:0] b_tmr;
  logic [3:0] c_bus, c_x0, c_x1, c_y0, c_y1, c_r, c_m, c_i, c_o;
  logic       c_eq, c_c, c_int;
  logic [7:0] c_tmr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  computational_unit_gen #(.DW(4), .TW(8), .TMR_AUTO(1)) u_a (
    .clk(clk), .reset(reset), .ir_nibble(ir_nibble),
    .source_sel(source_sel), .reg_en(reg_en), .i_sel(i_sel),
    .x_sel(x_sel), .y_sel(y_sel), .dm(dm4), .i_pins(pins4),
    .isr(isr), .data_bus(a_bus), .x0(a_x0), .x1(a_x1),
    .y0(a_y0), .y1(a_y1), .r(a_r), .m(a_m), .i(a_i),
    .o_reg(a_o), .r_eq_0(a_eq), .r_carry(a_c),
    .interrupt(a_int), .timer(a_tmr)
  );

  computational_unit_gen #(.DW(8), .TW(8), .TMR_AUTO(1)) u_b (
    .clk(clk), .reset(reset), .ir_nibble(ir_nibble),
    .source_sel(source_sel), .reg_en(reg_en), .i_sel(i_sel),
    .x_sel(x_sel), .y_sel(y_sel), .dm(dm8), .i_pins(pins8),
    .isr(isr), .data_bus(b_bus), .x0(b_x0), .x1(b_x1),
    .y0(b_y0), .y1(b_y1), .r(b_r), .m(b_m), .i(b_i),
    .o_reg(b_o), .r_eq_0(b_eq), .r_carry(b_c),
    .interrupt(b_int), .timer(b_tmr)
  );

  computational_unit_gen #(.DW(4), .TW(8), .TMR_AUTO(0)) u_c (
    .clk(clk), .reset(reset), .ir_nibble(ir_nibble),
    .source_sel(source_sel), .reg_en(reg_en), .i_sel(i_sel),
    .x_sel(x_sel), .y_sel(y_sel), .dm(dm4), .i_pins(pins4),
    .isr(isr), .data_bus(c_bus), .x0(c_x0), .x1(c_x1),
    .y0(c_y0), .y1(c_y1), .r(c_r), .m(c_m), .i(c_i),
    .o_reg(c_o), .r_eq_0(c_eq), .r_carry(c_c),
    .interrupt(c_int), .timer(c_tmr)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] src, input logic [9:0] en);
    source_sel = src;
    reg_en     = en;
    step();
    reg_en     = '0;
  endtask

  initial begin
    reset = 1'b1;
    ir_nibble = '0; source_sel = '0; reg_en = '0;
    i_sel = 0; x_sel = 0; y_sel = 0; isr = 0;
    dm4 = '0; pins4 = '0; dm8 = '0; pins8 = '0;
    #12;
    chk("rst_r", a_r, 0);
    chk("rst_eq", a_eq, 1);
    chk("rst_int", a_int, 0);
    chk("rst_tmr", a_tmr, 0);
    reset = 1'b0;
    step();

    // DW=8 add/sub with carry and borrow
    pins4 = 4'h5;
    pins8 = 8'hF0; wr(4'd9, 10'h001);
    pins8 = 8'h20; wr(4'd9, 10'h004);
    chk("b_x0", b_x0, 8'hF0);
    ir_nibble = 4'h2; wr(4'd0, 10'h010);
    chk("b_add_r", b_r, 8'h10);
    chk("b_add_c", b_c, 1);
    chk("b_add_eq", b_eq, 0);
    pins8 = 8'h20; wr(4'd9, 10'h002);
    pins8 = 8'hF0; wr(4'd9, 10'h008);
    x_sel = 1; y_sel = 1;
    ir_nibble = 4'h1; wr(4'd0, 10'h010);
    chk("b_sub_r", b_r, 8'h30);
    chk("b_sub_c", b_c, 1);
    y_sel = 0;
    wr(4'd0, 10'h010);
    chk("b_sub0_r", b_r, 0);
    chk("b_sub0_eq", b_eq, 1);
    chk("b_sub0_c", b_c, 0);
    x_sel = 0;
    ir_nibble = 4'hA; source_sel = 4'd8; #1;
    chk("b_imm_bus", b_bus, 8'h0A);

    // DW=4 arithmetic, multiply, i+m wrap
    ir_nibble = 4'hF; wr(4'd8, 10'h001);
    wr(4'd8, 10'h004);
    ir_nibble = 4'h1; wr(4'd0, 10'h010);
    chk("a_sub_r", a_r, 0);
    chk("a_sub_eq", a_eq, 1);
    chk("a_sub_c", a_c, 0);
    ir_nibble = 4'h2; wr(4'd0, 10'h010);
    chk("a_add_r", a_r, 4'hE);
    chk("a_add_c", a_c, 1);
    ir_nibble = 4'h3; wr(4'd0, 10'h010);
    chk("a_mulh", a_r, 4'hE);
    chk("a_mulh_c", a_c, 1);
    ir_nibble = 4'h4; wr(4'd0, 10'h010);
    chk("a_mull", a_r, 4'h1);
    chk("a_mull_eq", a_eq, 0);
    ir_nibble = 4'h0; wr(4'd0, 10'h010);
    chk("a_neg", a_r, 4'h1);
    ir_nibble = 4'h3; wr(4'd8, 10'h020);
    ir_nibble = 4'hE; wr(4'd8, 10'h040);
    chk("a_i_ld", a_i, 4'hE);
    i_sel = 1; wr(4'd0, 10'h040); i_sel = 0;
    chk("a_i_wrap", a_i, 4'h1);
    source_sel = 4'd5; #1;
    chk("a_bus_m", a_bus, 4'h3);

    // Auto-reload timer, period 3
    ir_nibble = 4'h3; wr(4'd8, 10'h200);
    chk("t_ld", a_tmr, 3);
    step();
    chk("t_2", a_tmr, 2);
    step();
    chk("t_1", a_tmr, 1);
    chk("t_int0", a_int, 0);
    step();
    chk("t_term_tmr", a_tmr, 0);
    chk("t_term_int", a_int, 1);
    isr = 1; #1;
    chk("t_mask", a_int, 0);
    step(); isr = 0;
    chk("t_reload", a_tmr, 3);
    chk("t_ack", a_int, 0);
    step(2);
    chk("t_pre2", a_int, 0);
    step();
    chk("t_term2", a_int, 1);
    step();
    chk("t_hold", a_int, 1);
    chk("t_hold_tmr", a_tmr, 3);

    // Acknowledge on the same edge as a terminal event
    step(2);
    chk("t5_tmr1", a_tmr, 1);
    isr = 1;
    step();
    chk("t5_tmr0", a_tmr, 0);
    chk("t5_masked", a_int, 0);
    isr = 0; #1;
    chk("t5_reassert", a_int, 1);

    // Asynchronous reset mid-run
    #2 reset = 1'b1;
    #1;
    chk("mr_x0", a_x0, 0);
    chk("mr_r", a_r, 0);
    chk("mr_i", a_i, 0);
    chk("mr_eq", a_eq, 1);
    chk("mr_c", a_c, 0);
    chk("mr_int", a_int, 0);
    chk("mr_tmr", a_tmr, 0);
    chk("mr_b_x0", b_x0, 0);
    #10 reset = 1'b0;
    step(12);
    chk("post_int", a_int, 0);
    chk("post_tmr", a_tmr, 0);

    // One-shot timer, period 2 then 5
    ir_nibble = 4'h2; wr(4'd8, 10'h200);
    chk("os_ld", c_tmr, 2);
    step();
    chk("os_1", c_tmr, 1);
    step();
    chk("os_term", c_tmr, 0);
    chk("os_int", c_int, 1);
    isr = 1; step(); isr = 0;
    step(3);
    chk("os_done_tmr", c_tmr, 0);
    chk("os_done_int", c_int, 0);
    ir_nibble = 4'h5; wr(4'd8, 10'h200);
    chk("os_ld5", c_tmr, 5);
    for (int k = 4; k >= 1; k--) begin
      step();
      chk("os_cnt", c_tmr, k);
      chk("os_cnt_int", c_int, 0);
    end
    step();
    chk("os_term5", c_tmr, 0);
    chk("os_int5", c_int, 1);
    step(3);
    chk("os_stay0", c_tmr, 0);

    // Period 1 toggles 1 -> 0 -> 1
    ir_nibble = 4'h1; wr(4'd8, 10'h200);
    chk("p1_a", a_tmr, 1);
    step();
    chk("p1_b", a_tmr, 0);
    step();
    chk("p1_c", a_tmr, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
